iq_buf_writer: RTL and testbench

Write-side controller for the 256x16 sample buffer. It accepts a stream of 16-bit I/Q sample words from the AT86RF215 deserializer and generates the buffer's write strobe, address and data. The buffer is handled as two ping-pong halves of 128 words each. The block raises a per-half ready flag and an MCU interrupt when a half fills, and drops samples with an overflow indication when the MCU has not released the next half.

---
 rtl/iq_buf_writer_pkg.sv | 17 +
 rtl/iq_buf_writer_if.sv | 30 +++
 rtl/iq_buf_writer.sv | 138 +++++++++++++
 tb/tb_iq_buf_writer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/iq_buf_writer_pkg.sv
// Shared types and constants for the I/Q sample-buffer write controller.
// Used by iq_buf_writer; see that file for the OVF_CNT_EN build option.
package iq_buf_writer_pkg;

  localparam int AW_DEF     = 8;
  localparam int DW_DEF     = 16;
  localparam int HALF_WORDS = 128;
  localparam int H0         = 0;
  localparam int H1         = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2
  } state_t;

endpackage

// File: rtl/iq_buf_writer_if.sv
// Sample stream in / buffer write port out, bundled for iq_buf_writer.
// slave = the writer block, master = its environment.
interface iq_buf_writer_if #(
  parameter int AW = 8,
  parameter int DW = 16
) ();

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  modport master (
    output in_valid,
    output in_data,
    input  wen,
    input  waddr,
    input  wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output wen,
    output waddr,
    output wdata
  );

endinterface

// File: rtl/iq_buf_writer.sv
// Ping-pong write controller for the 2^AW x DW I/Q sample buffer.
// Define OVF_CNT_EN to add the 16-bit saturating ovf_count port.
module iq_buf_writer
  import iq_buf_writer_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  iq_buf_writer_if.slave bus,
  input  logic [1:0]  half_ack,
  input  logic        ovf_clr,
  output logic [1:0]  half_ready,
  output logic        irq,
`ifdef OVF_CNT_EN
  output logic [15:0] ovf_count,
`endif
  output logic        overflow
);

  localparam int HALF = 1 << (AW - 1);
  localparam logic [AW-1:0] OFS = AW'(HALF - 1);

  state_t        state, state_d;
  logic [AW-1:0] ptr, ptr_d;
  logic          do_wr;
  logic          drop;
  logic          at_base;
  logic          blocked;
  logic          wr_last;
  logic [1:0]    set_v;

  assign at_base = (ptr & OFS) == '0;
  assign blocked = at_base & half_ready[ptr[AW-1]];

  assign wr_last = bus.wen & ((bus.waddr & OFS) == OFS);
  assign set_v[H0] = wr_last & (bus.waddr[AW-1] == 1'b0);
  assign set_v[H1] = wr_last & (bus.waddr[AW-1] == 1'b1);

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    do_wr   = 1'b0;
    drop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_d = FILL;
          ptr_d   = '0;
        end
      end
      FILL, STALL: begin
        if (!enable) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else if (blocked) begin
          state_d = STALL;
          drop    = bus.in_valid;
        end else begin
          // release is seen here, so a sample right after the ack is kept
          state_d = FILL;
          if (bus.in_valid) begin
            do_wr = 1'b1;
            ptr_d = ptr + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wen   <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
    end else begin
      bus.wen <= do_wr;
      if (do_wr) begin
        bus.waddr <= ptr;
        bus.wdata <= bus.in_data;
      end
    end
  end

  // set beats a coincident ack on the same bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_ready <= '0;
      irq        <= 1'b0;
    end else begin
      half_ready <= (half_ready & ~half_ack) | set_v;
      irq        <= |half_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (drop) begin
      if (ovf_clr) begin
        ovf_count <= 16'd1;
      end else if (ovf_count != 16'hFFFF) begin
        ovf_count <= ovf_count + 16'd1;
      end
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_iq_buf_writer.sv
// Directed bench for iq_buf_writer: fill, stall/drop, ack, enable, reset.
// Builds with or without OVF_CNT_EN.
module tb_iq_buf_writer;
  import iq_buf_writer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] half_ack;
  logic       ovf_clr;
  logic [1:0] half_ready;
  logic       irq;
  logic       overflow;
`ifdef OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  int nchk = 0;
  int nerr = 0;

  iq_buf_writer_if #(.AW(8), .DW(16)) bus ();

  iq_buf_writer #(.AW(8), .DW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .bus        (bus.slave),
    .half_ack   (half_ack),
    .ovf_clr    (ovf_clr),
    .half_ready (half_ready),
    .irq        (irq),
`ifdef OVF_CNT_EN
    .ovf_count  (ovf_count),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wr(input logic w, input logic [7:0] a,
                                     input logic [15:0] d);
    return {39'd0, w, a, d};
  endfunction

  function automatic logic [63:0] wr_now();
    return {39'd0, bus.wen, bus.waddr, bus.wdata};
  endfunction

  // streams n words starting at address a0, data d0+i, checking each write
  task automatic stream(input string tag, input int n, input int a0,
                        input int d0);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(d0 + i);
      tick();
      if (wr_now() !== wr(1'b1, 8'(a0 + i), 16'(d0 + i))) begin
        if (bad == 0)
          chk({tag, "_word"}, wr_now(), wr(1'b1, 8'(a0 + i), 16'(d0 + i)));
        bad++;
      end
    end
    bus.in_valid = 1'b0;
    chk({tag, "_all_ok"}, 64'(bad), 64'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    half_ack     = 2'b00;
    ovf_clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #12;
    chk("rst_wr", wr_now(), 64'd0);
    chk("rst_flags", {61'd0, half_ready, irq}, 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
`ifdef OVF_CNT_EN
    chk("rst_cnt", 64'(ovf_count), 64'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    tick();

    // half 0 fills, flag one cycle after last wen, irq one later
    stream("h0", HALF_WORDS, 0, 0);
    tick();
    chk("h0_ready", 64'(half_ready), 64'd1);
    chk("h0_irq_lag", 64'(irq), 64'd0);
    chk("h0_wen_low", 64'(bus.wen), 64'd0);
    tick();
    chk("h0_irq", 64'(irq), 64'd1);

    // half 1 fills, then next sample is dropped
    stream("h1", HALF_WORDS, 128, 16'h100);
    tick();
    chk("h1_ready", 64'(half_ready), 64'd3);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hDEAD;
    tick();
    bus.in_valid = 1'b0;
    chk("drop_wen", 64'(bus.wen), 64'd0);
    chk("drop_ovf", 64'(overflow), 64'd1);
`ifdef OVF_CNT_EN
    chk("drop_cnt", 64'(ovf_count), 64'd1);
`endif

    // release half 0, next sample lands at 0
    half_ack = 2'b01;
    tick();
    half_ack     = 2'b00;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBEEF;
    tick();
    bus.in_valid = 1'b0;
    chk("rel_wr", wr_now(), wr(1'b1, 8'd0, 16'hBEEF));
    tick();
    chk("rel_ready", 64'(half_ready), 64'd2);
    chk("rel_ovf", 64'(overflow), 64'd1);

    // write to 127 with coincident stray ack on bit 0: set wins
    stream("h0b", 126, 1, 16'h200);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7777;
    tick();
    bus.in_valid = 1'b0;
    chk("last_wr", wr_now(), wr(1'b1, 8'd127, 16'h7777));
    half_ack = 2'b01;
    tick();
    half_ack = 2'b00;
    chk("set_wins", 64'(half_ready), 64'd3);

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);
`ifdef OVF_CNT_EN
    chk("cnt_clr", 64'(ovf_count), 64'd0);
`endif

    // release both, 50 writes into half 1, then drop enable
    half_ack = 2'b11;
    tick();
    half_ack = 2'b00;
    chk("ack_both", 64'(half_ready), 64'd0);
    tick();
    chk("irq_clr", 64'(irq), 64'd0);
    stream("part", 50, 128, 16'h300);
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h5555;
    tick();
    bus.in_valid = 1'b0;
    chk("reen_wr", wr_now(), wr(1'b1, 8'd0, 16'h5555));
    tick();
    chk("reen_ready", 64'(half_ready), 64'd0);

    // reset in the middle of a 200-sample stream
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 200; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(16'h400 + i);
      tick();
      if (i == 99) begin
        chk("pre_rst_wen", 64'(bus.wen), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", wr_now(), 64'd0);
        chk("mid_rst_flags", {61'd0, half_ready, irq}, 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        break;
      end
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("rst_hold_wen", 64'(bus.wen), 64'd0);
    rst_n = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_wr", wr_now(), wr(1'b1, 8'd0, 16'h1234));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
